pe_arr_sched: RTL and testbench

- Sequencer for the weight-stationary/skewed systolic PE array: on a start command it streams K weight and activation vectors from two tile buffers into the array's edge ports.
- Applies the diagonal skew the array needs: row lane i delayed i steps, column lane j delayed j steps.
- Asserts fire on the first array step, then drains with zeros until the last partial product has propagated, and reports done.
- Sits between the tile buffers and the PE array, and paces itself to the array's divided local clock.

---
 rtl/pe_arr_pkg.sv | 18 +
 rtl/pe_skew_line.sv | 29 ++
 rtl/pe_arr_sched.sv | 148 ++++++++++++++
 tb/tb_pe_arr_sched.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_arr_pkg.sv
// rtl/pe_arr_pkg.sv - shared state encoding and sizing helpers for the PE array scheduler
package pe_arr_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Steps needed for the last partial product to cross the skewed array.
    function automatic int drain_len(input int rows, input int cols);
        return rows + cols - 1;
    endfunction

endpackage

// File: rtl/pe_skew_line.sv
// rtl/pe_skew_line.sv - per-lane delay chain feeding one array edge port
module pe_skew_line #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stages [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < DEPTH; s++) stages[s] <= '0;
        end else if (clr) begin
            for (int s = 0; s < DEPTH; s++) stages[s] <= '0;
        end else if (en) begin
            stages[0] <= din;
            for (int s = 1; s < DEPTH; s++) stages[s] <= stages[s-1];
        end
    end

    assign dout = stages[DEPTH-1];

endmodule

// File: rtl/pe_arr_sched.sv
// rtl/pe_arr_sched.sv - streams skewed weight/activation vectors into the systolic PE array
module pe_arr_sched
    import pe_arr_pkg::*;
#(
    parameter int ROWS     = 16,
    parameter int COLS     = 16,
    parameter int K_W      = 10,
    parameter int STEP_DIV = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [K_W-1:0]      k_len,
    input  logic                abort,
    output logic                busy,
    output logic                done,
    output logic                rd_en,
    output logic [K_W-1:0]      rd_addr,
    input  logic [8*ROWS-1:0]   rd_w_data,
    input  logic [8*COLS-1:0]   rd_a_data,
    output logic [8*ROWS-1:0]   in_w_port,
    output logic [8*COLS-1:0]   in_a_port,
    output logic                fire
);

    localparam int DIV_W = $clog2(STEP_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(STEP_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_RD     = DIV_W'(STEP_DIV - 2);
    localparam logic [K_W-1:0]   DRAIN_LAST = K_W'(drain_len(ROWS, COLS) - 1);

    state_t           state, state_nxt;
    logic [K_W-1:0]   k_reg;
    logic [K_W-1:0]   step_cnt;
    logic [DIV_W-1:0] div_cnt;
    logic             active;
    logic             tick;
    logic             abort_hit;
    logic             skew_en;
    logic             skew_clr;
    logic [8*ROWS-1:0] feed_w;
    logic [8*COLS-1:0] feed_a;

    assign active    = (state == FEED) || (state == DRAIN);
    assign tick      = active && (div_cnt == DIV_LAST);
    assign abort_hit = abort && (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = (state != IDLE);
        done      = 1'b0;
        rd_en     = 1'b0;
        rd_addr   = '0;
        case (state)
            IDLE: begin
                if (start) state_nxt = (k_len != '0) ? FEED : DONE;
            end
            FEED: begin
                // Read one cycle ahead so the buffer data lands on the tick.
                rd_en   = (div_cnt == DIV_RD);
                rd_addr = rd_en ? step_cnt : '0;
                if (tick && (step_cnt == k_reg - K_W'(1))) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (tick && (step_cnt == DRAIN_LAST)) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (abort_hit) state_nxt = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k_reg    <= '0;
            step_cnt <= '0;
            div_cnt  <= '0;
            fire     <= 1'b0;
        end else if (abort_hit) begin
            step_cnt <= '0;
            div_cnt  <= '0;
            fire     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) k_reg <= k_len;
                    step_cnt <= '0;
                    div_cnt  <= '0;
                    fire     <= 1'b0;
                end
                FEED, DRAIN: begin
                    div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
                    if (tick) begin
                        step_cnt <= (state_nxt != state) ? '0 : step_cnt + K_W'(1);
                        // Fire spans exactly the first array step of the feed.
                        fire     <= (state == FEED) && (step_cnt == '0);
                    end
                end
                default: begin
                    step_cnt <= '0;
                    div_cnt  <= '0;
                    fire     <= 1'b0;
                end
            endcase
        end
    end

    assign skew_en  = tick && !abort_hit;
    assign skew_clr = abort_hit || (state == DONE);
    assign feed_w   = (state == FEED) ? rd_w_data : '0;
    assign feed_a   = (state == FEED) ? rd_a_data : '0;

    for (genvar i = 0; i < ROWS; i++) begin : g_w
        pe_skew_line #(
            .DEPTH(i + 1),
            .WIDTH(DATA_W)
        ) u_line (
            .clk  (clk),
            .rst  (rst),
            .en   (skew_en),
            .clr  (skew_clr),
            .din  (feed_w[i*DATA_W +: DATA_W]),
            .dout (in_w_port[i*DATA_W +: DATA_W])
        );
    end

    for (genvar j = 0; j < COLS; j++) begin : g_a
        pe_skew_line #(
            .DEPTH(j + 1),
            .WIDTH(DATA_W)
        ) u_line (
            .clk  (clk),
            .rst  (rst),
            .en   (skew_en),
            .clr  (skew_clr),
            .din  (feed_a[j*DATA_W +: DATA_W]),
            .dout (in_a_port[j*DATA_W +: DATA_W])
        );
    end

endmodule

// File: tb/tb_pe_arr_sched.sv
// tb/tb_pe_arr_sched.sv - directed bench for the PE array scheduler
module tb_pe_arr_sched;

    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int K_W  = 10;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic               start, abort, busy, done, rd_en, fire;
    logic [K_W-1:0]     k_len, rd_addr;
    logic [8*ROWS-1:0]  rd_w_data = '0, in_w_port;
    logic [8*COLS-1:0]  rd_a_data = '0, in_a_port;

    logic               start3, abort3, busy3, done3, rd_en3, fire3;
    logic [K_W-1:0]     k_len3, rd_addr3;
    logic [8*ROWS-1:0]  rd_w3 = '0, in_w3;
    logic [8*COLS-1:0]  rd_a3 = '0, in_a3;

    pe_arr_sched #(.ROWS(ROWS), .COLS(COLS), .K_W(K_W), .STEP_DIV(2)) dut (
        .clk(clk), .rst(rst), .start(start), .k_len(k_len), .abort(abort),
        .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_w_data(rd_w_data), .rd_a_data(rd_a_data),
        .in_w_port(in_w_port), .in_a_port(in_a_port), .fire(fire)
    );

    pe_arr_sched #(.ROWS(ROWS), .COLS(COLS), .K_W(K_W), .STEP_DIV(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .k_len(k_len3), .abort(abort3),
        .busy(busy3), .done(done3), .rd_en(rd_en3), .rd_addr(rd_addr3),
        .rd_w_data(rd_w3), .rd_a_data(rd_a3),
        .in_w_port(in_w3), .in_a_port(in_a3), .fire(fire3)
    );

    function automatic logic [8*ROWS-1:0] w_vec(input logic [K_W-1:0] n);
        logic [8*ROWS-1:0] v;
        for (int l = 0; l < ROWS; l++) v[l*8 +: 8] = 8'(l + 16 * int'(n));
        return v;
    endfunction

    function automatic logic [8*COLS-1:0] a_vec(input logic [K_W-1:0] n);
        logic [8*COLS-1:0] v;
        for (int l = 0; l < COLS; l++) v[l*8 +: 8] = 8'(l + 32 * int'(n));
        return v;
    endfunction

    function automatic logic [7:0] lane(input logic [31:0] v, input int l);
        return v[l*8 +: 8];
    endfunction

    always @(posedge clk) begin
        if (rd_en) begin
            rd_w_data <= w_vec(rd_addr);
            rd_a_data <= a_vec(rd_addr);
        end
        if (rd_en3) begin
            rd_w3 <= w_vec(rd_addr3);
            rd_a3 <= a_vec(rd_addr3);
        end
    end

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int             done_cyc, n_done, n_rd, fire_first, n_fire, max_addr;
    logic [K_W-1:0] addrs [8];
    logic [7:0]     w1 [32];
    logic [7:0]     w2 [32];
    logic [7:0]     a3 [32];
    logic           bz [32];

    task automatic clear_stats();
        done_cyc = -1; n_done = 0; n_rd = 0; fire_first = -1; n_fire = 0; max_addr = 0;
        for (int i = 0; i < 8; i++) addrs[i] = '0;
        for (int i = 0; i < 32; i++) begin
            w1[i] = '0; w2[i] = '0; a3[i] = '0; bz[i] = 1'b0;
        end
    endtask

    task automatic record(input int c);
        if (rd_en) begin
            if (n_rd < 8) addrs[n_rd] = rd_addr;
            n_rd++;
        end
        if (fire) begin
            if (fire_first < 0) fire_first = c;
            n_fire++;
        end
        if (done) begin
            if (done_cyc < 0) done_cyc = c;
            n_done++;
        end
        if (c < 32) begin
            w1[c] = lane(in_w_port, 1);
            w2[c] = lane(in_w_port, 2);
            a3[c] = lane(in_a_port, 3);
            bz[c] = busy;
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; k_len = '0;
        start3 = 1'b0; abort3 = 1'b0; k_len3 = '0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rd_en", rd_en, 0);
        chk("rst_rd_addr", rd_addr, 0);
        chk("rst_fire", fire, 0);
        chk("rst_in_w", in_w_port, 0);
        chk("rst_in_a", in_a_port, 0);
        step(); step();
        rst = 1'b0;
        step();

        // K=3 run, with a stray start pulse while busy
        clear_stats();
        k_len = 10'd3; start = 1'b1;
        chk("k3_busy_c0", busy, 0);
        for (int c = 1; c <= 26; c++) begin
            step();
            if (c == 1)  start = 1'b0;
            if (c == 10) start = 1'b1;
            if (c == 11) start = 1'b0;
            record(c);
        end
        chk("k3_rd_count", n_rd, 3);
        chk("k3_rd_addr0", addrs[0], 0);
        chk("k3_rd_addr1", addrs[1], 1);
        chk("k3_rd_addr2", addrs[2], 2);
        chk("k3_w1_c5", w1[5], 8'h01);
        chk("k3_w1_c7", w1[7], 8'h11);
        chk("k3_w2_c6", w2[6], 8'h00);
        chk("k3_w2_c7", w2[7], 8'h02);
        chk("k3_w2_c9", w2[9], 8'h12);
        chk("k3_w2_c11", w2[11], 8'h22);
        chk("k3_w2_c13", w2[13], 8'h00);
        chk("k3_a3_c8", a3[8], 8'h00);
        chk("k3_a3_c9", a3[9], 8'h03);
        chk("k3_a3_c11", a3[11], 8'h23);
        chk("k3_a3_c13", a3[13], 8'h43);
        chk("k3_a3_c15", a3[15], 8'h00);
        chk("k3_fire_first", fire_first, 3);
        chk("k3_fire_cycles", n_fire, 2);
        chk("k3_done_cycle", done_cyc, 21);
        chk("k3_done_count", n_done, 1);
        chk("k3_busy_c1", bz[1], 1);
        chk("k3_busy_c21", bz[21], 1);
        chk("k3_busy_c22", bz[22], 0);
        chk("k3_busy_c26", bz[26], 0);
        chk("k3_ports_idle_w", in_w_port, 0);

        // K=0: immediate done, no reads, no fire
        clear_stats();
        k_len = 10'd0; start = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            step();
            if (c == 1) start = 1'b0;
            record(c);
        end
        chk("k0_done_cycle", done_cyc, 1);
        chk("k0_done_count", n_done, 1);
        chk("k0_rd_count", n_rd, 0);
        chk("k0_fire_count", n_fire, 0);
        chk("k0_busy_c1", bz[1], 1);
        chk("k0_busy_c2", bz[2], 0);

        // abort during the second drain step
        clear_stats();
        k_len = 10'd3; start = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            step();
            if (c == 1) start = 1'b0;
        end
        chk("ab_pre_w2", lane(in_w_port, 2), 8'h12);
        chk("ab_pre_busy", busy, 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("ab_busy", busy, 0);
        chk("ab_in_w", in_w_port, 0);
        chk("ab_in_a", in_a_port, 0);
        chk("ab_fire", fire, 0);
        chk("ab_done", done, 0);
        for (int c = 1; c <= 5; c++) begin
            step();
            record(c);
        end
        chk("ab_no_done", n_done, 0);

        clear_stats();
        k_len = 10'd2; start = 1'b1;
        for (int c = 1; c <= 22; c++) begin
            step();
            if (c == 1) start = 1'b0;
            record(c);
        end
        chk("k2_done_cycle", done_cyc, 19);
        chk("k2_done_count", n_done, 1);
        chk("k2_rd_count", n_rd, 2);

        // async reset between clock edges during FEED
        clear_stats();
        k_len = 10'd3; start = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            step();
            if (c == 1) start = 1'b0;
        end
        chk("ar_pre_w0", lane(in_w_port, 0), 8'h10);
        chk("ar_pre_rd_en", rd_en, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_busy", busy, 0);
        chk("ar_rd_en", rd_en, 0);
        chk("ar_rd_addr", rd_addr, 0);
        chk("ar_in_w", in_w_port, 0);
        chk("ar_in_a", in_a_port, 0);
        chk("ar_fire", fire, 0);
        step();
        rst = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            step();
            record(c);
        end
        chk("ar_no_done", n_done, 0);
        chk("ar_idle", busy, 0);

        // maximum K on the STEP_DIV=3 instance
        clear_stats();
        k_len3 = 10'd1023; start3 = 1'b1;
        for (int c = 1; c <= 3100; c++) begin
            step();
            if (c == 1) start3 = 1'b0;
            if (rd_en3) begin
                n_rd++;
                if (int'(rd_addr3) > max_addr) max_addr = int'(rd_addr3);
            end
            if (done3) begin
                if (done_cyc < 0) done_cyc = c;
                n_done++;
            end
        end
        chk("kmax_rd_count", n_rd, 1023);
        chk("kmax_max_addr", max_addr, 1022);
        chk("kmax_done_cycle", done_cyc, 3091);
        chk("kmax_done_count", n_done, 1);
        chk("kmax_idle_fire", fire3, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
